dac_spi_multi: RTL and testbench

- Parametrised serial DAC driver, successor to the single-channel 12-bit free-running DAC7513 driver.
- Sends one MSB-first frame per request to one of NUM_CH DACs. The DACs share the clock and data lines; each channel has its own sync/chip-select line.
- Uses a start/busy/done handshake instead of free-running. Sits between waveform generators (sine tables, NCO) and the board DAC pins.

---
 rtl/dac_spi_multi.sv | 174 +++++++++++++++++
 tb/tb_dac_spi_multi.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_multi.sv
// dac_spi_multi: serial DAC driver for NUM_CH DACs sharing clock and data, with a separate
// active-low sync line per channel. One MSB-first frame per accepted start request.
// Optional build macro DAC_SPI_PD_EN adds the i_pd port (power-down bits in the frame).
module dac_spi_multi #(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned FRAME_W = 16,
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned CH_W    = 1,
  parameter int unsigned CLK_DIV = 25,
  parameter int unsigned GAP     = 2
) (
  input  logic              i_clk50,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [CH_W-1:0]   i_ch,
  input  logic [DATA_W-1:0] i_dacdata,
`ifdef DAC_SPI_PD_EN
  input  logic [1:0]        i_pd,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic              o_dacclk,
  output logic [NUM_CH-1:0] o_daccs,
  output logic              o_dacdout
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CntW = $clog2(FRAME_W + 1);
  localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StGap, StDone} state_e;

  state_e              r_state, w_state_d;
  logic [DivW-1:0]     r_div, w_div_d;
  logic [FRAME_W-1:0]  r_shift, w_shift_d;
  logic [CntW-1:0]     r_bitcnt, w_bitcnt_d;
  logic [GapW-1:0]     r_gap, w_gap_d;
  logic                r_dacclk, w_dacclk_d;
  logic [NUM_CH-1:0]   r_daccs, w_daccs_d;
  logic                r_dacdout, w_dacdout_d;
  logic                r_busy, w_busy_d;
  logic                r_done, w_done_d;

  logic                w_tick;
  logic                w_ch_ok;
  logic [1:0]          w_pd;
  logic [FRAME_W-1:0]  w_frame;

`ifdef DAC_SPI_PD_EN
  assign w_pd = i_pd;
`else
  assign w_pd = 2'b00;
`endif

  // Upper frame bits are zero-filled by the width cast.
  assign w_frame = FRAME_W'({w_pd, i_dacdata});
  assign w_ch_ok = (32'(i_ch) < NUM_CH);
  assign w_tick  = (r_div == DivW'(CLK_DIV - 1));

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk50) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_div     <= '0;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_gap     <= '0;
      r_dacclk  <= 1'b1;
      r_daccs   <= '1;
      r_dacdout <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_div     <= w_div_d;
      r_shift   <= w_shift_d;
      r_bitcnt  <= w_bitcnt_d;
      r_gap     <= w_gap_d;
      r_dacclk  <= w_dacclk_d;
      r_daccs   <= w_daccs_d;
      r_dacdout <= w_dacdout_d;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
    end
  end

  // Next-state logic: frame sequencing, half-period divider and serial line values.
  always_comb begin
    w_state_d   = r_state;
    w_div_d     = '0;
    w_shift_d   = r_shift;
    w_bitcnt_d  = r_bitcnt;
    w_gap_d     = r_gap;
    w_dacclk_d  = r_dacclk;
    w_daccs_d   = r_daccs;
    w_dacdout_d = r_dacdout;
    w_busy_d    = r_busy;
    w_done_d    = 1'b0;

    // Divider runs only while a frame is in flight.
    if (r_busy) begin
      w_div_d = w_tick ? '0 : r_div + 1'b1;
    end

    unique case (r_state)
      StIdle: begin
        if (i_start && w_ch_ok) begin
          w_state_d   = StSetup;
          w_busy_d    = 1'b1;
          w_shift_d   = w_frame;
          w_bitcnt_d  = '0;
          w_gap_d     = '0;
          w_dacclk_d  = 1'b1;
          w_daccs_d   = ~(NUM_CH'(1) << i_ch);
          w_dacdout_d = w_frame[FRAME_W-1];
        end
      end
      StSetup: begin
        if (w_tick) begin
          w_state_d = StShift;
        end
      end
      StShift: begin
        if (w_tick) begin
          if (r_dacclk) begin
            // Falling edge: DAC samples the current bit.
            w_dacclk_d = 1'b0;
            w_bitcnt_d = r_bitcnt + 1'b1;
          end else if (r_bitcnt == CntW'(FRAME_W)) begin
            w_dacclk_d  = 1'b1;
            w_daccs_d   = '1;
            w_dacdout_d = 1'b0;
            if (GAP == 0) begin
              w_state_d = StDone;
              w_busy_d  = 1'b0;
              w_done_d  = 1'b1;
            end else begin
              w_state_d = StGap;
            end
          end else begin
            // Rising edge: present the next bit together with the edge.
            w_dacclk_d  = 1'b1;
            w_shift_d   = r_shift << 1;
            w_dacdout_d = r_shift[FRAME_W-2];
          end
        end
      end
      StGap: begin
        if (w_tick) begin
          if (r_gap == GapW'(GAP - 1)) begin
            w_state_d = StDone;
            w_busy_d  = 1'b0;
            w_done_d  = 1'b1;
          end else begin
            w_gap_d = r_gap + 1'b1;
          end
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_dacclk  = r_dacclk;
  assign o_daccs   = r_daccs;
  assign o_dacdout = r_dacdout;

endmodule

// File: tb/tb_dac_spi_multi.sv
// tb_dac_spi_multi: directed bench for dac_spi_multi (CH_W=2 so an out-of-range channel
// can be requested). A negedge monitor captures serial bits and timing of the DAC lines.
module tb_dac_spi_multi;

  localparam int CLK_DIV = 25;
  localparam int FRAME_CYC = (1 + 2 * 16) * CLK_DIV;  // sync low cycles per frame
  localparam int LATENCY = 1 + (1 + 2 * 16 + 2) * CLK_DIV;
`ifdef DAC_SPI_PD_EN
  localparam logic [15:0] PdFrame = 16'h3123;
`else
  localparam logic [15:0] PdFrame = 16'h0123;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  ch = 2'd0;
  logic [11:0] data = 12'd0;
  logic [1:0]  pd = 2'd0;
  logic        busy, done, dacclk, dacdout;
  logic [1:0]  daccs;

  dac_spi_multi #(
    .DATA_W (12),
    .FRAME_W(16),
    .NUM_CH (2),
    .CH_W   (2),
    .CLK_DIV(CLK_DIV),
    .GAP    (2)
  ) u_dut (
    .i_clk50  (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_ch     (ch),
    .i_dacdata(data),
`ifdef DAC_SPI_PD_EN
    .i_pd     (pd),
`endif
    .o_busy   (busy),
    .o_done   (done),
    .o_dacclk (dacclk),
    .o_daccs  (daccs),
    .o_dacdout(dacdout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor, sampled mid-cycle.
  logic        p_clk = 1'b1, p_dout = 1'b0;
  logic [1:0]  p_cs = 2'b11;
  logic [15:0] cap = '0;
  bit          hi_in_frame = 1'b0;
  int run = 0, nfall = 0, bad_low = 0, bad_high = 0, inv_err = 0;
  int cs0_low = 0, cs1_low = 0, cs_up_cyc = 0, cs_dn_cyc = 0, done_cnt = 0;

  always @(negedge clk) begin
    p_clk  <= dacclk;
    p_dout <= dacdout;
    p_cs   <= daccs;
    if (dacclk != p_clk) begin
      run <= 1;
      if (!dacclk) begin
        cap   <= {cap[14:0], dacdout};
        nfall <= nfall + 1;
        if (hi_in_frame && run != CLK_DIV) bad_high <= bad_high + 1;
      end else begin
        if (run != CLK_DIV) bad_low <= bad_low + 1;
        hi_in_frame <= 1'b1;
      end
    end else begin
      run <= run + 1;
    end
    if (daccs == 2'b11) hi_in_frame <= 1'b0;
    if ((!dacclk && dacdout != p_dout) || daccs == 2'b00) inv_err <= inv_err + 1;
    if (!daccs[0]) cs0_low <= cs0_low + 1;
    if (!daccs[1]) cs1_low <= cs1_low + 1;
    if (p_cs != 2'b11 && daccs == 2'b11) cs_up_cyc <= cyc;
    if (p_cs == 2'b11 && daccs != 2'b11) cs_dn_cyc <= cyc;
    if (done) done_cnt <= done_cnt + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits up to limit cycles for a done pulse; td is the cycle it was seen.
  task automatic wait_done(input int limit, output bit got, output int td, output logic bsy);
    got = 1'b0;
    td  = 0;
    bsy = 1'bx;
    for (int i = 0; i < limit && !got; i++) begin
      tick(1);
      if (done === 1'b1) begin
        got = 1'b1;
        td  = cyc;
        bsy = busy;
      end
    end
  endtask

  // One full frame; poke injects a start with other ch/data/pd while busy.
  task automatic frame(input string tag, input logic [1:0] c, input logic [11:0] d,
                       input logic [1:0] p, input logic [15:0] expf, input bit poke);
    int t0, td, n0, bl0, bh0, z0, z1, dc0;
    bit got;
    logic bsy;
    n0 = nfall; bl0 = bad_low; bh0 = bad_high; z0 = cs0_low; z1 = cs1_low; dc0 = done_cnt;
    ch = c; data = d; pd = p; start = 1'b1; t0 = cyc;
    tick(1);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_cs"}, 32'(daccs), 32'(2'b11 & ~(2'b01 << c)));
    if (poke) begin
      tick(300);
      ch = ~c & 2'b01; data = ~d; pd = ~p; start = 1'b1;
      tick(1);
      start = 1'b0;
    end
    wait_done(1000, got, td, bsy);
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(td - t0), 32'(LATENCY));
    check({tag, "_busy_at_done"}, 32'(bsy), 32'd0);
    tick(1);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_bits"}, 32'(cap), 32'(expf));
    check({tag, "_nfall"}, 32'(nfall - n0), 32'd16);
    check({tag, "_low_len"}, 32'(bad_low - bl0), 32'd0);
    check({tag, "_high_len"}, 32'(bad_high - bh0), 32'd0);
    check({tag, "_cs0_cycles"}, 32'(cs0_low - z0), (c == 2'd0) ? 32'(FRAME_CYC) : 32'd0);
    check({tag, "_cs1_cycles"}, 32'(cs1_low - z1), (c == 2'd1) ? 32'(FRAME_CYC) : 32'd0);
    check({tag, "_done_count"}, 32'(done_cnt - dc0), 32'd1);
    check({tag, "_cs_high_before_done"}, 32'(td - cs_up_cyc), 32'(2 * CLK_DIV));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int idle_bad, dc0, n0, t0, td1, td2, cs_up1;
    bit got, hit;
    logic bsy;

    // Reset then idle.
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dacclk", 32'(dacclk), 32'd1);
    check("rst_daccs", 32'(daccs), 32'h3);
    check("rst_dacdout", 32'(dacdout), 32'd0);
    idle_bad = 0;
    for (int i = 0; i < 2000; i++) begin
      tick(1);
      if (busy !== 1'b0 || done !== 1'b0 || dacclk !== 1'b1 || daccs !== 2'b11 ||
          dacdout !== 1'b0) idle_bad++;
    end
    check("idle_2000", 32'(idle_bad), 32'd0);

    // Single frame on channel 0.
    frame("f0", 2'd0, 12'hA5C, 2'b00, 16'h0A5C, 1'b0);

    // Channel 1 with an ignored start while busy, then no stray done.
    tick(3);
    dc0 = done_cnt;
    frame("f1", 2'd1, 12'hFFF, 2'b00, 16'h0FFF, 1'b1);
    tick(1000);
    check("f1_no_extra_done", 32'(done_cnt - dc0), 32'd1);
    check("f1_idle_busy", 32'(busy), 32'd0);

    // Out-of-range channel is ignored.
    dc0 = done_cnt;
    ch = 2'd2; data = 12'h321; start = 1'b1;
    tick(1);
    start = 1'b0;
    check("ch2_busy", 32'(busy), 32'd0);
    check("ch2_cs", 32'(daccs), 32'h3);
    tick(1000);
    check("ch2_no_done", 32'(done_cnt - dc0), 32'd0);

    // Reset after the 7th falling edge.
    dc0 = done_cnt;
    n0 = nfall;
    ch = 2'd0; data = 12'h5A5; start = 1'b1;
    tick(1);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      tick(1);
      if (nfall - n0 == 7) hit = 1'b1;
    end
    check("abort_reached_7", 32'(hit), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("abort_cs", 32'(daccs), 32'h3);
    check("abort_dacclk", 32'(dacclk), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_dacdout", 32'(dacdout), 32'd0);
    tick(1);
    check("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    frame("recov", 2'd0, 12'h3C6, 2'b00, 16'h03C6, 1'b0);

    // Back-to-back with start held high.
    tick(3);
    ch = 2'd0; data = 12'h000; start = 1'b1; t0 = cyc;
    tick(1);
    data = 12'h800;
    wait_done(1000, got, td1, bsy);
    check("b2b_done1_seen", 32'(got), 32'd1);
    check("b2b_latency1", 32'(td1 - t0), 32'(LATENCY));
    check("b2b_bits1", 32'(cap), 32'h0000);
    cs_up1 = cs_up_cyc;
    tick(1);
    check("b2b_idle_cycle", 32'(busy), 32'd0);
    tick(1);
    check("b2b_second_accept", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(1000, got, td2, bsy);
    check("b2b_done2_seen", 32'(got), 32'd1);
    check("b2b_latency2", 32'(td2 - (td1 + 1)), 32'(LATENCY));
    tick(1);
    check("b2b_bits2", 32'(cap), 32'h0800);
    check("b2b_sync_gap", 32'((cs_dn_cyc - cs_up1) >= 2 * CLK_DIV), 32'd1);

    // Power-down bits (zero unless the option is built in).
    tick(3);
    frame("pd", 2'd0, 12'h123, 2'b11, PdFrame, 1'b0);

    check("line_invariants", 32'(inv_err), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
